// File: rtl/fft_frame_scheduler.sv
// Frame scheduler for the FFT front end: circular sample buffer pointers, fill tracking,
// and N_FFT-sample burst reads of overlapping frames advancing by HOP.
module fft_frame_scheduler #(
  parameter int N_FFT     = 256,
  parameter int HOP       = 128,
  parameter int BUF_DEPTH = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         smp_valid,
  output logic                         wr_en,
  output logic [$clog2(BUF_DEPTH)-1:0] wr_addr,
  input  logic                         fft_ready,
  output logic                         rd_en,
  output logic [$clog2(BUF_DEPTH)-1:0] rd_addr,
  output logic                         frame_start,
  output logic                         rd_valid,
  output logic                         rd_last,
  output logic [15:0]                  frame_cnt,
  output logic                         overflow
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0]   NFFT_W  = (AW+1)'(N_FFT);
  localparam logic [AW:0]   HOP_W   = (AW+1)'(HOP);
  localparam logic [AW-1:0] HOP_A   = AW'(HOP);
  localparam logic [AW-1:0] K_LAST  = AW'(N_FFT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] fbase_r;
  logic [AW-1:0] k_r;
  logic [AW:0]   fill_r;
  logic          full_s;
  logic          frame_done_s;
  logic          start_s;
  logic [AW:0]   fill_inc_s;
  logic [AW:0]   fill_dec_s;

  // Next-state decode plus the combinational strobes; en low suppresses everything.
  always_comb begin
    state_next_s = state_r;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    frame_start  = 1'b0;
    frame_done_s = 1'b0;
    start_s      = 1'b0;
    full_s       = (fill_r == DEPTH_W);
    wr_en        = en & smp_valid & ~full_s;
    case (state_r)
      IDLE: begin
        if (en && (fill_r >= NFFT_W) && fft_ready) begin
          state_next_s = READ;
          start_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        if (!en) begin
          state_next_s = IDLE;
        end else begin
          rd_en       = 1'b1;
          frame_start = (k_r == {AW{1'b0}});
          if (k_r == K_LAST) begin
            frame_done_s = 1'b1;
            state_next_s = IDLE;
          end else begin
            state_next_s = READ;
          end
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Fill moves by +1 per accepted sample and -HOP per completed frame, both possibly at once.
  always_comb begin
    fill_inc_s = {{AW{1'b0}}, wr_en};
    if (frame_done_s) begin
      fill_dec_s = HOP_W;
    end else begin
      fill_dec_s = {(AW+1){1'b0}};
    end
  end

  assign wr_addr = wptr_r;
  // Address is held at zero outside a burst so the read port is quiet between frames.
  assign rd_addr = rd_en ? (fbase_r + k_r) : {AW{1'b0}};

  // State, pointers and registered read-pipeline flags; en low clears like reset.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_r   <= IDLE;
      wptr_r    <= {AW{1'b0}};
      fbase_r   <= {AW{1'b0}};
      fill_r    <= {(AW+1){1'b0}};
      k_r       <= {AW{1'b0}};
      frame_cnt <= 16'd0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      fill_r   <= fill_r + fill_inc_s - fill_dec_s;
      rd_valid <= rd_en;
      rd_last  <= frame_done_s;
      if (wr_en) begin
        wptr_r <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (smp_valid && full_s) begin
        overflow <= 1'b1;
      end
      if (start_s) begin
        k_r <= {AW{1'b0}};
      end else if (rd_en) begin
        k_r <= k_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (frame_done_s) begin
        fbase_r   <= fbase_r + HOP_A;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: sample-count model checked every cycle plus directed
// scenarios with hand-computed addresses, latencies and fill levels.
module tb_fft_frame_scheduler;

  localparam int N_FFT = 256;
  localparam int HOP   = 128;
  localparam int BD    = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          smp_valid;
  logic          fft_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          frame_start;
  logic          rd_valid;
  logic          rd_last;
  logic [15:0]   frame_cnt;
  logic          overflow;

  fft_frame_scheduler #(.N_FFT(N_FFT), .HOP(HOP), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .en(en), .smp_valid(smp_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .fft_ready(fft_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .frame_start(frame_start),
    .rd_valid(rd_valid), .rd_last(rd_last), .frame_cnt(frame_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: total samples accepted and total samples retired; fill is their difference.
  int m_wr = 0, m_base = 0, m_idx = 0, m_frames = 0;
  bit m_reading = 0, m_ovf = 0, m_pv = 0, m_pl = 0;

  always @(posedge clk) begin
    int  f;
    bit  done;
    if (rst || !en) begin
      m_wr = 0; m_base = 0; m_idx = 0; m_frames = 0;
      m_reading = 0; m_ovf = 0; m_pv = 0; m_pl = 0;
    end else begin
      f    = m_wr - m_base;
      done = m_reading && (m_idx == N_FFT - 1);
      m_pv = m_reading;
      m_pl = done;
      if (smp_valid && f == BD) m_ovf = 1;
      if (smp_valid && f != BD) m_wr++;
      if (m_reading) begin
        if (done) begin
          m_reading = 0;
          m_base += HOP;
          m_frames++;
        end else begin
          m_idx++;
        end
      end else if (f >= N_FFT && fft_ready) begin
        m_reading = 1;
        m_idx = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit e_rd;
    bit e_wr;
    e_wr = en && smp_valid && (m_wr - m_base != BD);
    e_rd = en && m_reading;
    check("wr_en", wr_en, e_wr);
    check("wr_addr", wr_addr, m_wr % BD);
    check("rd_en", rd_en, e_rd);
    check("rd_addr", rd_addr, e_rd ? (m_base + m_idx) % BD : 0);
    check("frame_start", frame_start, e_rd && m_idx == 0);
    check("rd_valid", rd_valid, m_pv);
    check("rd_last", rd_last, m_pl);
    check("frame_cnt", frame_cnt, m_frames % 65536);
    check("overflow", overflow, m_ovf);
  end

  // Event log used by the directed checks.
  int cyc = 0, last_wr_cyc = 0, fs_cyc = 0, wr_cnt = 0, rd_n = 0, last_cnt = 0;
  int last_addr = -1, prev_addr = 0;
  bit fs_seen = 0;
  int rd_log [1024];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) begin
      last_wr_cyc = cyc;
      wr_cnt++;
    end
    if (frame_start) begin
      fs_seen = 1;
      fs_cyc  = cyc;
    end
    if (rd_valid && rd_last) begin
      last_cnt++;
      last_addr = prev_addr;
    end
    if (rd_en) begin
      if (rd_n < 1024) rd_log[rd_n] = int'(rd_addr);
      rd_n++;
      prev_addr = int'(rd_addr);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      smp_valid = 1'b1;
      tick(1);
    end
    smp_valid = 1'b0;
  endtask

  task automatic wait_fs(input int budget, input string name);
    fs_seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (fs_seen) break;
    end
    check(name, fs_seen, 1);
  endtask

  task automatic restart();
    en = 1'b0;
    tick(1);
    en = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int l0;

  initial begin
    rst = 1'b1; en = 1'b0; smp_valid = 1'b0; fft_ready = 1'b0;
    tick(3);
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_fill", dut.fill_r, 0);
    rst = 1'b0;

    // T1: 255 samples do not start a frame; the 256th starts one two cycles later.
    en = 1'b1; fft_ready = 1'b1; fs_seen = 0;
    push(255);
    tick(5);
    check("t1_no_start", fs_seen, 0);
    rd_n = 0;
    push(1);
    wait_fs(10, "t1_start");
    check("t1_latency", fs_cyc - last_wr_cyc, 2);

    // T2: first frame addresses and completion state.
    tick(260);
    check("t2_rd_count", rd_n, 256);
    check("t2_first_addr", rd_log[0], 0);
    check("t2_last_addr", rd_log[255], 255);
    check("t2_last_cnt", last_cnt, 1);
    check("t2_last_data_addr", last_addr, 255);
    check("t2_frame_cnt", frame_cnt, 1);
    check("t2_fill", dut.fill_r, 128);
    check("t2_model_fill", m_wr - m_base, 128);
    check("t2_fbase", dut.fbase_r, 128);

    // T3: overlapping frames, fourth one wraps the buffer.
    rd_n = 0;
    push(128);
    wait_fs(10, "t3_start2");
    tick(260);
    check("t3_f2_first", rd_log[0], 128);
    check("t3_f2_last", rd_log[255], 383);
    rd_n = 0;
    push(128);
    wait_fs(10, "t3_start3");
    tick(260);
    check("t3_f3_first", rd_log[0], 256);
    check("t3_f3_last", rd_log[255], 511);
    rd_n = 0;
    push(128);
    wait_fs(10, "t3_start4");
    tick(260);
    check("t3_f4_first", rd_log[0], 384);
    check("t3_f4_top", rd_log[127], 511);
    check("t3_f4_wrap", rd_log[128], 0);
    check("t3_f4_last", rd_log[255], 127);
    check("t3_frame_cnt", frame_cnt, 4);

    // T4: fill the buffer with the FFT stalled, then drain one frame.
    restart();
    fft_ready = 1'b0;
    wr_cnt = 0;
    push(513);
    check("t4_wr_count", wr_cnt, 512);
    check("t4_overflow", overflow, 1);
    tick(5);
    check("t4_overflow_sticky", overflow, 1);
    fft_ready = 1'b1;
    rd_n = 0;
    wait_fs(10, "t4_start");
    tick(256);
    check("t4_first_addr", rd_log[0], 0);
    check("t4_last_addr", rd_log[255], 255);
    check("t4_fill", dut.fill_r, 384);
    check("t4_model_fill", m_wr - m_base, 384);
    fft_ready = 1'b0;
    tick(300);

    // T5: a sample arriving on the frame_done cycle with fill 300.
    restart();
    fft_ready = 1'b0;
    push(300);
    fft_ready = 1'b1;
    wait_fs(10, "t5_start");
    tick(254);
    fft_ready = 1'b0;
    smp_valid = 1'b1;
    #1;
    check("t5_done_addr", rd_addr, 255);
    tick(1);
    smp_valid = 1'b0;
    check("t5_fill", dut.fill_r, 173);
    check("t5_model_fill", m_wr - m_base, 173);
    check("t5_rd_last", rd_last, 1);
    tick(5);

    // T6: abort mid-frame, then confirm the T1 timing on re-enable.
    restart();
    fft_ready = 1'b1;
    push(256);
    wait_fs(10, "t6_start");
    tick(99);
    l0 = last_cnt;
    en = 1'b0;
    #1;
    check("t6_rd_en_abort", rd_en, 0);
    tick(1);
    check("t6_fill", dut.fill_r, 0);
    check("t6_frame_cnt", frame_cnt, 0);
    tick(3);
    check("t6_no_rd_last", last_cnt, l0);
    en = 1'b1;
    fs_seen = 0;
    push(255);
    tick(5);
    check("t6_no_start", fs_seen, 0);
    push(1);
    wait_fs(10, "t6_restart");
    check("t6_latency", fs_cyc - last_wr_cyc, 2);
    tick(270);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
